multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Sequential multi-precision adder stage that sits directly upstream of the 16-bit carry-lookahead adder's consumers.
- Accepts an N-word operand pair as a stream of WIDTH-bit slices, least-significant word first.
- Computes each slice as a + b + carry, with the carry chained between words, and emits one sum word per input word.
- Reports the final carry-out and signed overflow at the end of the operation.
- Valid/ready on both sides so it can sit between an operand loader and a result sink.

Parameters:
- WIDTH, 16, bits per word slice.
- MAX_WORDS, 4, maximum words per operation; CW = $clog2(MAX_WORDS+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- num_words  in  CW  words in this operation; sampled with start; legal range 1..MAX_WORDS.
- cin  in  1  carry-in to word 0; sampled with start.
- abort  in  1  synchronous cancel.
- in_valid  in  1  a_word/b_word valid.
- in_ready  out  1  stage can accept a word.
- a_word  in  WIDTH  operand A slice.
- b_word  in  WIDTH  operand B slice.
- out_valid  out  1  sum_word valid.
- out_ready  in  1  sink accepts sum_word.
- sum_word  out  WIDTH  result slice.
- out_last  out  1  sum_word is the final (most-significant) word.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at completion.
- cout  out  1  final carry-out; held until the next start.
- ovf  out  1  signed overflow of the final word; held until the next start.
- err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; carry=0; count=0.
  - in_ready, out_valid, out_last, busy, done, cout, ovf and err are all 0.
  - sum_word=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with 1 ≤ num_words ≤ MAX_WORDS: latch num_words, carry=cin, count=0; clear cout and ovf; go to RUN next cycle.
  - start=1 with num_words=0 or num_words>MAX_WORDS: err=1 for one cycle; stay in IDLE.
- RUN:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept occurs when in_valid && in_ready.
  - On accept, with full = a_word + b_word + carry at WIDTH+1 bits:
    - sum_word = full[WIDTH-1:0]; carry = full[WIDTH].
    - out_valid=1; out_last = (count == latched num_words-1); count increments.
  - On the last accept:
    - cout = full[WIDTH].
    - ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
    - Go to DRAIN.
- Output register:
  - Latency is 1 cycle from accept to out_valid.
  - While out_valid && !out_ready, sum_word and out_last are held stable and in_ready=0.
  - When out_ready=1 and there is no new accept, out_valid is cleared.
  - Back-to-back throughput is one word per cycle when out_ready is held 1.
- DRAIN:
  - in_ready=0.
  - When the last word is consumed (out_valid && out_ready), out_valid and out_last clear, done=1 for one cycle, state returns to IDLE.
- busy = (state != IDLE).
- start outside IDLE is ignored; no err.
- abort:
  - Any state goes to IDLE next cycle; out_valid and out_last clear; carry and count clear.
  - No done pulse; cout and ovf are not updated.
  - abort takes priority over a simultaneous accept or drain.
- Reset asserted mid-operation: everything returns to reset values immediately; no done pulse.
- Arithmetic is unsigned modulo 2^WIDTH per slice; the carry chain is exact across words.
- Input data is ignored whenever in_ready=0.

Test Plan:
- Single word, num_words=1, cin=1, a=0x0002, b=0x0002 → sum_word=0x0005, out_last=1, cout=0, ovf=0, done one cycle after the handshake.
- Carry chain, num_words=2, cin=0, words (0xFFFF,0x0001) then (0x0001,0x0000) → sum words 0x0000 then 0x0002; cout=0.
- Full ripple, num_words=4, cin=1, all a=0xFFFF, b=0x0000 → four sum words 0x0000, out_last only on the 4th, cout=1.
- Signed overflow, num_words=1, cin=0, a=0x7FFF, b=0x0001 → sum_word=0x8000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first word → in_ready=0 and sum_word held stable for those cycles; release → remaining words stream with no loss or duplication.
- Errors and cancel:
  - start with num_words=0 → err pulse; busy stays 0.
  - abort after word 2 of 4 → IDLE next cycle, out_valid=0, no done.
  - rst_n low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Sequential multi-precision adder: consumes operand word pairs LS-word first,
// chains the carry between words, and streams one registered sum word per input word.
module multiword_add_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 4,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    num_words,
  input  logic             cin,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds data stable while valid && !ready; ready never waits on valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            carry;
  logic [CW-1:0]   count;
  logic [CW-1:0]   nw_q;
  logic            accept;
  logic            consume;
  logic            nw_legal;
  logic            start_ok;
  logic            start_bad;
  logic            is_last;
  logic [WIDTH:0]  full;

  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign nw_legal  = (num_words != '0) && (num_words <= CW'(MAX_WORDS));
  assign start_ok  = (state == S_IDLE) && start && nw_legal;
  assign start_bad = (state == S_IDLE) && start && !nw_legal;
  assign is_last   = (count == nw_q - CW'(1));
  assign full      = {1'b0, a_word} + {1'b0, b_word} + {{WIDTH{1'b0}}, carry};
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_ok) state_next = S_RUN;
        S_RUN:   if (accept && is_last) state_next = S_DRAIN;
        S_DRAIN: if (consume) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath and output register; abort wins over any same-cycle accept or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry     <= 1'b0;
      count     <= '0;
      nw_q      <= '0;
      sum_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        carry     <= 1'b0;
        count     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              nw_q  <= num_words;
              carry <= cin;
              count <= '0;
              cout  <= 1'b0;
              ovf   <= 1'b0;
            end else if (start_bad) begin
              err <= 1'b1;
            end
          end
          S_RUN: begin
            if (accept) begin
              sum_word  <= full[WIDTH-1:0];
              carry     <= full[WIDTH];
              out_valid <= 1'b1;
              out_last  <= is_last;
              count     <= count + CW'(1);
              if (is_last) begin
                cout <= full[WIDTH];
                ovf  <= (a_word[WIDTH-1] == b_word[WIDTH-1]) &&
                        (full[WIDTH-1] != a_word[WIDTH-1]);
              end
            end else if (consume) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (consume) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: hand-computed sum words go into an
// expected queue that a sink-side monitor drains; flags are checked directly.
module tb_multiword_add_sequencer;
  localparam int W  = 16;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_words;
  logic          cin;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_word;
  logic [W-1:0]  b_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum_word;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          cout;
  logic          ovf;
  logic          err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;

  multiword_add_sequencer #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .cin(cin),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word),
    .b_word(b_word), .out_valid(out_valid), .out_ready(out_ready),
    .sum_word(sum_word), .out_last(out_last), .busy(busy), .done(done),
    .cout(cout), .ovf(ovf), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every sink handshake must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum_word_last", {15'd0, out_last, sum_word}, {15'd0, mon_e});
      end
    end
  end

  // driver tasks
  task automatic start_op(input int n, input logic c);
    @(posedge clk); #1;
    start = 1'b1; num_words = CW'(n); cin = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] s, input logic last);
    logic got;
    got = 1'b0;
    a_word = a; b_word = b; in_valid = 1'b1;
    exp_q.push_back({last, s});
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    check("in_ready_seen", {31'd0, got}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input logic c_exp, input logic o_exp);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", {31'd0, got}, 1);
    check("cout", {31'd0, cout}, {31'd0, c_exp});
    check("ovf", {31'd0, ovf}, {31'd0, o_exp});
    check("busy_after_done", {31'd0, busy}, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; num_words = '0; cin = 1'b0; abort = 1'b0;
    in_valid = 1'b0; a_word = '0; b_word = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_last", {31'd0, out_last}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_cout_ovf_err", {29'd0, cout, ovf, err}, 0);
    check("rst_sum_word", {16'd0, sum_word}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single word: 2 + 2 + cin 1; done one cycle after the sink handshake
    start_op(1, 1'b1);
    send_word(16'h0002, 16'h0002, 16'h0005, 1'b1);
    @(negedge clk);
    check("t1_valid", {31'd0, out_valid}, 1);
    check("t1_done_early", {31'd0, done}, 0);
    check("t1_state_drain", {30'd0, dbg_state}, 2);
    @(negedge clk);
    check("t1_done", {31'd0, done}, 1);
    check("t1_busy", {31'd0, busy}, 0);
    check("t1_cout", {31'd0, cout}, 0);
    check("t1_ovf", {31'd0, ovf}, 0);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 0);

    // carry chain across two words
    start_op(2, 1'b0);
    send_word(16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    send_word(16'h0001, 16'h0000, 16'h0002, 1'b1);
    finish_op(1'b0, 1'b0);

    // full ripple: FFFF + 0 + 1 carries through all four words
    start_op(4, 1'b1);
    for (int i = 0; i < 4; i++) send_word(16'hFFFF, 16'h0000, 16'h0000, i == 3);
    finish_op(1'b1, 1'b0);

    // signed overflow
    start_op(1, 1'b0);
    send_word(16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    finish_op(1'b0, 1'b1);

    // backpressure: sink stalls for three cycles after the first word
    start_op(3, 1'b0);
    send_word(16'h1234, 16'h1111, 16'h2345, 1'b0);
    out_ready = 1'b0;
    a_word = 16'hFFFF; b_word = 16'h0002; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_sum_held", {16'd0, sum_word}, 32'h2345);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    send_word(16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    send_word(16'h0001, 16'h0001, 16'h0003, 1'b1);
    finish_op(1'b0, 1'b0);

    // illegal starts: zero words and too many words
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; num_words = (k == 0) ? CW'(0) : CW'(MW + 1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("err_pulse", {31'd0, err}, 1);
      check("err_busy", {31'd0, busy}, 0);
      @(negedge clk);
      check("err_clear", {31'd0, err}, 0);
      check("err_state", {30'd0, dbg_state}, 0);
    end

    // abort after word 2 of 4
    start_op(4, 1'b0);
    send_word(16'h0001, 16'h0002, 16'h0003, 1'b0);
    send_word(16'h0004, 16'h0005, 16'h0009, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_in_ready", {31'd0, in_ready}, 0);
    check("abort_state", {30'd0, dbg_state}, 0);
    repeat (3) begin
      check("abort_no_done", {31'd0, done}, 0);
      @(negedge clk);
    end

    // reset mid-RUN clears outputs without waiting for a clock edge
    start_op(4, 1'b1);
    send_word(16'h0001, 16'h0001, 16'h0003, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_out_valid", {31'd0, out_valid}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_in_ready", {31'd0, in_ready}, 0);
    check("mrst_sum_word", {16'd0, sum_word}, 0);
    check("mrst_flags", {27'd0, out_last, done, cout, ovf, err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // recovery after reset: 0x8000 + 0x8000 wraps with carry and overflow
    start_op(1, 1'b0);
    send_word(16'h8000, 16'h8000, 16'h0000, 1'b1);
    finish_op(1'b1, 1'b1);

    repeat (2) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
